n4_unpack: RTL and testbench
============================

// Module: n4_unpack
// PURPOSE
//  Decoder for the n4 zero-skip stream. n4 stores each nonzero word as a 2-word SRAM
//  entry (value at base+idx, position offset at base+idx+1, idx += 2 per entry).
//  n4_unpack reads those entries back and regenerates the dense stream, zeros
//  re-inserted, over a valid/ready handshake to the downstream datapath.
// PARAMETERS
//  N          16  data word width; also width of stored offset, position, length
//  ADDR_SIZE  16  SRAM address width
// PORTS
//  i_clk        in   1          clock, rising edge
//  i_rst_n      in   1          asynchronous active-low reset
//  i_start      in   1          start decode; sampled in IDLE only
//  i_base_addr  in   ADDR_SIZE  SRAM address of first entry
//  i_len        in   N          dense output length (words)
//  i_num_nz     in   N          number of stored entries
//  o_sram_rd_en out  1          SRAM read strobe; rdata valid next cycle
//  o_sram_addr  out  ADDR_SIZE  SRAM read address
//  i_sram_rdata in   N          SRAM read data (1-cycle latency)
//  o_data       out  N          dense output word
//  o_valid      out  1          o_data valid
//  i_ready      in   1          downstream accepts when o_valid & i_ready
//  o_busy       out  1          high in every state except IDLE
//  o_done       out  1          1-cycle pulse when the last word is accepted / len==0
//  o_err        out  1          sticky: out-of-order offset seen; cleared by i_start
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; idx, pos, counters, entry buffer cleared.
//  Start latches base, len, num_nz; idx=0, pos=0, buf_vld=0, o_err=0.
//  FSM:
//   IDLE   : i_start & len==0 -> DONE; i_start & num_nz>0 -> RD_VAL; else -> EMIT.
//   RD_VAL : rd_en=1, addr=base+idx -> RD_OFF.
//   RD_OFF : rd_en=1, addr=base+idx+1; val<=rdata -> CAP.
//   CAP    : off<=rdata; idx+=2; nz_rem-=1. If rdata<pos: o_err=1, entry dropped,
//            -> RD_VAL if nz_rem>0 after decrement, else EMIT. Else buf_vld=1 -> EMIT.
//   EMIT   : o_valid=1; o_data = (buf_vld & off==pos) ? val : 0. On accept: pos+=1;
//            if pos==len-1 -> DONE; else if matched entry consumed: buf_vld=0,
//            -> RD_VAL if nz_rem>0, else stay EMIT (zeros only).
//   DONE   : o_done=1 one cycle, o_busy=1 -> IDLE.
//  o_data/o_valid stable while o_valid & ~i_ready; o_valid never drops without accept.
//  o_valid low in RD_VAL/RD_OFF/CAP (fetch bubble, 3 cycles per entry).
//  Latency: start accepted in cycle 0 -> first o_valid in cycle 4 (num_nz>0) or
//   cycle 1 (num_nz==0).
//  Addresses base+idx, base+idx+1 wrap modulo 2^ADDR_SIZE. pos, idx never wrap
//   within a run (len < 2^N).
//  Entries with off >= len are never emitted; decode ends at pos==len-1 regardless of
//   remaining nz_rem (no extra SRAM reads after DONE).
//  Duplicate offset (off==previous) counts as off<pos -> o_err, dropped.
//  i_start while busy ignored. Async reset mid-run -> IDLE immediately, o_valid=0,
//   rd_en=0; no o_done.
// TESTING
//  1 SRAM {5,1,7,4}, base=0x10, len=5, nz=2, ready=1 -> reads 0x10..0x13; o_data
//    stream 0,5,0,0,7; o_done once after 5th accept; o_err=0.
//  2 Same as 1 with i_ready toggling 1010.. -> same stream, o_data held while stalled.
//  3 len=3, nz=0 -> no rd_en; o_valid from cycle 1; stream 0,0,0; o_done.
//  4 len=0, nz=2 -> no o_valid, no rd_en; o_done cycle after start.
//  5 SRAM {9,3,4,1,6,4}, len=6, nz=3 -> stream 0,0,0,9,6,0; o_err=1 (entry 4@1 dropped).
//  6 base=0xFFFE, entry {3,0}, len=2, nz=1 -> addrs 0xFFFE,0xFFFF; stream 3,0.
//    Repeat with i_rst_n low after 1st accept -> outputs 0, IDLE, no o_done.

Source files
------------

// File: rtl/n4_unpack.sv
// n4 zero-skip stream decoder: fetches {value, offset} entry pairs from SRAM and
// regenerates the dense word stream with zeros re-inserted over valid/ready.
module n4_unpack #(
    parameter int unsigned N         = 16,
    parameter int unsigned ADDR_SIZE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [ADDR_SIZE-1:0] i_base_addr,
    input  logic [N-1:0]         i_len,
    input  logic [N-1:0]         i_num_nz,
    output logic                 o_sram_rd_en,
    output logic [ADDR_SIZE-1:0] o_sram_addr,
    input  logic [N-1:0]         i_sram_rdata,
    output logic [N-1:0]         o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_VAL,
        S_RD_OFF,
        S_CAP,
        S_EMIT,
        S_DONE
    } state_t;

    state_t               state_q,   state_d;
    logic [ADDR_SIZE-1:0] base_q,    base_d;
    logic [ADDR_SIZE-1:0] idx_q,     idx_d;
    logic [N-1:0]         len_q,     len_d;
    logic [N-1:0]         nz_rem_q,  nz_rem_d;
    logic [N-1:0]         pos_q,     pos_d;
    logic [N-1:0]         val_q,     val_d;
    logic [N-1:0]         off_q,     off_d;
    logic                 buf_vld_q, buf_vld_d;
    logic                 err_q,     err_d;

    logic                 match;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            nz_rem_q  <= '0;
            pos_q     <= '0;
            val_q     <= '0;
            off_q     <= '0;
            buf_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            nz_rem_q  <= nz_rem_d;
            pos_q     <= pos_d;
            val_q     <= val_d;
            off_q     <= off_d;
            buf_vld_q <= buf_vld_d;
            err_q     <= err_d;
        end
    end

    // The buffered entry is emitted only at its own position; otherwise a zero goes out.
    assign match = buf_vld_q && (off_q == pos_q);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        idx_d        = idx_q;
        len_d        = len_q;
        nz_rem_d     = nz_rem_q;
        pos_d        = pos_q;
        val_d        = val_q;
        off_d        = off_q;
        buf_vld_d    = buf_vld_q;
        err_d        = err_q;
        o_sram_rd_en = 1'b0;
        o_sram_addr  = '0;
        o_valid      = 1'b0;
        o_data       = '0;
        o_done       = 1'b0;
        o_busy       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    base_d    = i_base_addr;
                    len_d     = i_len;
                    nz_rem_d  = i_num_nz;
                    idx_d     = '0;
                    pos_d     = '0;
                    buf_vld_d = 1'b0;
                    err_d     = 1'b0;
                    if (i_len == '0)
                        state_d = S_DONE;
                    else if (i_num_nz != '0)
                        state_d = S_RD_VAL;
                    else
                        state_d = S_EMIT;
                end
            end
            S_RD_VAL: begin
                o_sram_rd_en = 1'b1;
                o_sram_addr  = base_q + idx_q;
                state_d      = S_RD_OFF;
            end
            S_RD_OFF: begin
                o_sram_rd_en = 1'b1;
                o_sram_addr  = base_q + idx_q + ADDR_SIZE'(1);
                val_d        = i_sram_rdata;
                state_d      = S_CAP;
            end
            S_CAP: begin
                off_d    = i_sram_rdata;
                idx_d    = idx_q + ADDR_SIZE'(2);
                nz_rem_d = nz_rem_q - N'(1);
                // Offsets behind the cursor (incl. duplicates) are dropped and flagged.
                if (i_sram_rdata < pos_q) begin
                    err_d   = 1'b1;
                    state_d = (nz_rem_d != '0) ? S_RD_VAL : S_EMIT;
                end else begin
                    buf_vld_d = 1'b1;
                    state_d   = S_EMIT;
                end
            end
            S_EMIT: begin
                o_valid = 1'b1;
                o_data  = match ? val_q : '0;
                if (i_ready) begin
                    pos_d = pos_q + N'(1);
                    if (pos_q == len_q - N'(1)) begin
                        state_d = S_DONE;
                    end else if (match) begin
                        buf_vld_d = 1'b0;
                        if (nz_rem_q != '0)
                            state_d = S_RD_VAL;
                    end
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_err = err_q;

endmodule

// File: tb/tb_n4_unpack.sv
// Bench for n4_unpack: directed vector table, mid-run reset sequence and randomized
// runs checked against a monotonic-offset reference model with an SRAM model.
module tb_n4_unpack;

    localparam int unsigned N = 16;
    localparam int unsigned A = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [A-1:0]  i_base_addr;
    logic [N-1:0]  i_len;
    logic [N-1:0]  i_num_nz;
    logic          o_sram_rd_en;
    logic [A-1:0]  o_sram_addr;
    logic [N-1:0]  sram_rdata;
    logic [N-1:0]  o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    always #5 clk = ~clk;

    n4_unpack #(.N(N), .ADDR_SIZE(A)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_len       (i_len),
        .i_num_nz    (i_num_nz),
        .o_sram_rd_en(o_sram_rd_en),
        .o_sram_addr (o_sram_addr),
        .i_sram_rdata(sram_rdata),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    // SRAM model with one-cycle read latency
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (o_sram_rd_en) sram_rdata <= mem[o_sram_addr];
    end

    int n_cmp = 0;
    int n_mis = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp_addr_q[$];
    logic        exp_err;

    typedef struct packed {
        logic [15:0]      base;
        logic [15:0]      len;
        logic [15:0]      nz;
        logic [5:0][15:0] sram;
        logic [5:0][15:0] words;
        int               n_sram;
        int               n_rd;
        int               mode;
        int               first_valid;
        logic             err;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [5:0][15:0] pk6(input logic [15:0] a, b, c, d, e, f);
        logic [5:0][15:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Runs one decode; expectations come from exp_q / exp_addr_q / exp_err.
    task automatic run_case(input logic [15:0] base, input logic [15:0] len,
                            input logic [15:0] nz, input int mode,
                            input int first_valid, input bit poke);
        int          done_cnt   = 0;
        bit          seen_valid = 1'b0;
        bit          stalled    = 1'b0;
        bit          tog        = 1'b1;
        bit          r;
        logic [15:0] held       = '0;
        @(negedge clk);
        check("idle_busy", o_busy, 0);
        i_start = 1'b1; i_base_addr = base; i_len = len; i_num_nz = nz;
        @(negedge clk);
        i_start = 1'b0; i_base_addr = ~base; i_len = 16'($urandom); i_num_nz = 16'($urandom);
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (o_sram_rd_en) begin
                check("rd_expected", exp_addr_q.size() != 0, 1);
                if (exp_addr_q.size() != 0) check("rd_addr", o_sram_addr, exp_addr_q.pop_front());
            end
            if (o_done) begin
                done_cnt++;
                if (len == 16'd0) check("done_cycle_len0", cyc, 1);
                check("done_no_valid", o_valid, 0);
                break;
            end
            if (stalled) check("valid_held", o_valid, 1);
            if (o_valid) begin
                if (!seen_valid && first_valid >= 0) check("first_valid_cycle", cyc, first_valid);
                seen_valid = 1'b1;
                if (stalled) check("data_held", o_data, held);
                case (mode)
                    0:       r = 1'b1;
                    1:       r = tog;
                    default: r = 1'($urandom_range(0, 1));
                endcase
                if (r) begin
                    check("word_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("data", o_data, exp_q.pop_front());
                    stalled = 1'b0;
                end else begin
                    held    = o_data;
                    stalled = 1'b1;
                end
            end else begin
                r = 1'($urandom_range(0, 1));
            end
            i_ready = r;
            tog     = ~tog;
            if (poke && cyc == 2) begin
                i_start = 1'b1; i_base_addr = base + 16'h100; i_len = len + 16'd3; i_num_nz = nz + 16'd1;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
        end
        i_start = 1'b0;
        check("done_pulses", done_cnt, 1);
        check("words_left", exp_q.size(), 0);
        check("reads_left", exp_addr_q.size(), 0);
        check("err", o_err, exp_err);
        @(negedge clk);
        check("done_single", o_done, 0);
        check("busy_after", o_busy, 0);
        check("err_sticky", o_err, exp_err);
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < v.n_sram; i++) mem[16'(v.base + 16'(i))] = v.sram[i];
        for (int i = 0; i < int'(v.len); i++) exp_q.push_back(v.words[i]);
        for (int i = 0; i < v.n_rd; i++) exp_addr_q.push_back(16'(v.base + 16'(i)));
        exp_err = v.err;
    endtask

    initial begin
        bit          got;
        logic [15:0] base, len, nz, prev, t, a;
        logic [15:0] offs[8];
        logic [15:0] vals[8];
        logic [15:0] dense[16];

        rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_len = '0; i_num_nz = '0; i_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;

        vecs[0] = '{base: 16'h10, len: 5, nz: 2, sram: pk6(5, 1, 7, 4, 0, 0),
                    words: pk6(0, 5, 0, 0, 7, 0), n_sram: 4, n_rd: 4, mode: 0, first_valid: 4, err: 1'b0};
        vecs[1] = vecs[0]; vecs[1].mode = 1;
        vecs[2] = '{base: 16'h40, len: 3, nz: 0, sram: pk6(0, 0, 0, 0, 0, 0),
                    words: pk6(0, 0, 0, 0, 0, 0), n_sram: 0, n_rd: 0, mode: 0, first_valid: 1, err: 1'b0};
        vecs[3] = '{base: 16'h50, len: 0, nz: 2, sram: pk6(1, 0, 2, 1, 0, 0),
                    words: pk6(0, 0, 0, 0, 0, 0), n_sram: 4, n_rd: 0, mode: 0, first_valid: -1, err: 1'b0};
        vecs[4] = '{base: 16'h20, len: 6, nz: 3, sram: pk6(9, 3, 4, 1, 6, 4),
                    words: pk6(0, 0, 0, 9, 6, 0), n_sram: 6, n_rd: 6, mode: 0, first_valid: 4, err: 1'b1};
        vecs[5] = '{base: 16'hFFFE, len: 2, nz: 1, sram: pk6(3, 0, 0, 0, 0, 0),
                    words: pk6(3, 0, 0, 0, 0, 0), n_sram: 2, n_rd: 2, mode: 0, first_valid: 4, err: 1'b0};
        vecs[6] = vecs[4]; vecs[6].mode = 2;

        #12;
        check("rst_valid", o_valid, 0);
        check("rst_rd_en", o_sram_rd_en, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_data", o_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            load_vec(vecs[v]);
            run_case(vecs[v].base, vecs[v].len, vecs[v].nz, vecs[v].mode, vecs[v].first_valid, 1'b0);
        end

        // Asynchronous reset after the first accepted word of the wrap-around case
        mem[16'hFFFE] = 16'd3; mem[16'hFFFF] = 16'd0;
        @(negedge clk);
        i_start = 1'b1; i_base_addr = 16'hFFFE; i_len = 16'd2; i_num_nz = 16'd1; i_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (o_valid) got = 1'b1;
            else @(negedge clk);
        end
        check("rstseq_valid_seen", got, 1);
        check("rstseq_first_word", o_data, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstseq_valid", o_valid, 0);
        check("rstseq_rd_en", o_sram_rd_en, 0);
        check("rstseq_busy", o_busy, 0);
        check("rstseq_done", o_done, 0);
        check("rstseq_data", o_data, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rstseq_no_done", o_done, 0);
            check("rstseq_idle", o_busy, 0);
        end
        rst_n = 1'b1;
        load_vec(vecs[5]);
        run_case(vecs[5].base, vecs[5].len, vecs[5].nz, 0, 4, 1'b0);

        // Randomized runs against the reference model
        for (int run = 0; run < 40; run++) begin
            base = 16'($urandom);
            if (run % 8 == 0) base = 16'hFFFF - 16'($urandom_range(0, 6));
            len  = 16'($urandom_range(0, 12));
            nz   = 16'($urandom_range(0, 6));
            prev = '0;
            for (int k = 0; k < int'(nz); k++) begin
                vals[k] = 16'($urandom_range(1, 65535));
                if ($urandom_range(0, 3) == 0) offs[k] = 16'($urandom_range(0, int'(len) + 1));
                else                           offs[k] = prev + 16'($urandom_range(0, 2));
                prev = offs[k] + 16'd1;
                a = base + 16'(2 * k);
                mem[a] = vals[k];
                a = a + 16'd1;
                mem[a] = offs[k];
            end
            // Model: entries must advance strictly past the last emitted offset;
            // decoding stops once an entry lands at or beyond the final position.
            for (int i = 0; i < 16; i++) dense[i] = '0;
            t = '0;
            exp_err = 1'b0;
            if (len != 16'd0) begin
                for (int k = 0; k < int'(nz); k++) begin
                    exp_addr_q.push_back(base + 16'(2 * k));
                    exp_addr_q.push_back(base + 16'(2 * k + 1));
                    if (offs[k] < t) begin
                        exp_err = 1'b1;
                    end else if (offs[k] >= len) begin
                        break;
                    end else begin
                        dense[offs[k]] = vals[k];
                        t = offs[k] + 16'd1;
                        if (offs[k] == len - 16'd1) break;
                    end
                end
            end
            for (int i = 0; i < int'(len); i++) exp_q.push_back(dense[i]);
            run_case(base, len, nz, int'($urandom_range(0, 2)),
                     (len == 16'd0) ? -1 : ((nz != 16'd0) ? 4 : 1),
                     (len >= 16'd2) && ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
